// File: rtl/resize_interp_engine_pkg.sv
// Shared widths and FSM encoding for the resize interpolation engine.
package resize_interp_engine_pkg;

  localparam int ADDR_SZ_DEF = 16;
  localparam int PIX_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_CALC = 3'd3,
    ST_WR   = 3'd4
  } state_e;

endpackage

// File: rtl/resize_interp_engine_half_to_q8.sv
// Half-precision weight to unsigned Q0.8; values >= 1.0 (incl. inf/NaN) saturate.
module half_to_q8 (
  input  logic [15:0] half,
  output logic [7:0]  q8
);

  logic [4:0]  expo;
  logic [10:0] mant;
  logic [4:0]  shamt;
  logic        sign_unused;

  assign sign_unused = half[15];
  assign expo        = half[14:10];
  assign mant        = {1'b1, half[9:0]};
  assign shamt       = 5'd17 - expo;

  always_comb begin
    q8 = '0;
    if (expo == 5'd0)
      q8 = '0;
    else if (expo >= 5'd15)
      q8 = 8'hff;
    else if (shamt < 5'd11)
      q8 = 8'(mant >> shamt);
  end

endmodule

// File: rtl/resize_interp_engine.sv
// Two-tap linear interpolation engine: read two pixels, blend by a half-float weight, write one.
module resize_interp_engine
  import resize_interp_engine_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ADDR_SZ = ADDR_SZ_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_SZ-1:0] in_src_addr1,
  input  logic [ADDR_SZ-1:0] in_src_addr2,
  input  logic [ADDR_SZ-1:0] in_des_addr,
  input  logic [15:0]        in_fraction,
  output logic               mem_rd_en,
  output logic [ADDR_SZ-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]   mem_rd_data,
  output logic               mem_wr_en,
  output logic [ADDR_SZ-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]   mem_wr_data,
  output logic               busy,
  output logic [31:0]        pix_count
);

  localparam int PW   = 2*PIX_W + 1;
  localparam int MAXV = (2**PIX_W) - 1;

  state_e             state, state_nxt;
  logic [ADDR_SZ-1:0] addr1, addr2, des_addr, rd_addr_q;
  logic [7:0]         f8, frac_q;
  logic [PIX_W-1:0]   p1, result, result_nxt;
  logic signed [PIX_W:0] diff;
  logic signed [PW-1:0]  prod, sum;
  logic               hs;

  half_to_q8 u_half_to_q8 (.half(in_fraction), .q8(f8));

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (hs) state_nxt = ST_RD1;
      ST_RD1:  state_nxt = ST_RD2;
      ST_RD2:  state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_WR;
      ST_WR:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read address is a mux over a hold register so it keeps its last value between reads.
  always_comb begin
    in_ready    = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    mem_rd_en   = 1'b0;
    mem_rd_addr = rd_addr_q;
    mem_wr_en   = (state == ST_WR);
    case (state)
      ST_RD1: begin mem_rd_en = 1'b1; mem_rd_addr = addr1; end
      ST_RD2: begin mem_rd_en = 1'b1; mem_rd_addr = addr2; end
      default: ;
    endcase
  end

  assign mem_wr_addr = des_addr;
  assign mem_wr_data = result;

  // p2 arrives on mem_rd_data during CALC and feeds the blend directly.
  always_comb begin
    diff = $signed({1'b0, mem_rd_data}) - $signed({1'b0, p1});
    prod = PW'(diff) * PW'($signed({1'b0, frac_q}));
    sum  = PW'($signed({1'b0, p1})) + (prod >>> 8);
    if (sum < 0)
      result_nxt = '0;
    else if (sum > PW'(MAXV))
      result_nxt = {PIX_W{1'b1}};
    else
      result_nxt = sum[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr1     <= '0;
      addr2     <= '0;
      des_addr  <= '0;
      frac_q    <= '0;
      rd_addr_q <= '0;
      p1        <= '0;
      result    <= '0;
      pix_count <= '0;
    end else begin
      rd_addr_q <= mem_rd_addr;
      if (hs) begin
        addr1    <= in_src_addr1;
        addr2    <= in_src_addr2;
        des_addr <= in_des_addr;
        frac_q   <= f8;
      end
      if (state == ST_RD2)  p1        <= mem_rd_data;
      if (state == ST_CALC) result    <= result_nxt;
      if (state == ST_WR)   pix_count <= pix_count + 32'd1;
    end
  end

endmodule

// File: doc/resize_interp_engine.md
RESIZE_INTERP_ENGINE -- requirements
Module: resize_interp_engine

Interface
REQ-001 Parameter PIX_W, default 8, pixel data width.
REQ-002 Parameter ADDR_SZ, default `ADDR_SZ from shared header, memory address width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request from resize address generator is present.
REQ-006 in_ready  output  1  engine accepts request this cycle.
REQ-007 in_src_addr1  input  ADDR_SZ  address of first (left/upper) source pixel.
REQ-008 in_src_addr2  input  ADDR_SZ  address of second (right/lower) source pixel.
REQ-009 in_des_addr  input  ADDR_SZ  destination write address.
REQ-010 in_fraction  input  16  IEEE half-precision interpolation weight, nominal range [0,1).
REQ-011 mem_rd_en  output  1  synchronous read strobe; data returns exactly 1 cycle later.
REQ-012 mem_rd_addr  output  ADDR_SZ  read address.
REQ-013 mem_rd_data  input  PIX_W  read data, valid the cycle after mem_rd_en.
REQ-014 mem_wr_en  output  1  write strobe, single cycle per pixel.
REQ-015 mem_wr_addr  output  ADDR_SZ  write address.
REQ-016 mem_wr_data  output  PIX_W  interpolated pixel.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 pix_count  output  32  number of pixels written since reset, wraps at 2^32.

Function
REQ-019 FSM states IDLE, RD1, RD2, CALC, WR; fixed sequence IDLE->RD1->RD2->CALC->WR->IDLE; no other transitions.
REQ-020 in_ready = 1 only in IDLE; handshake = in_valid & in_ready; on handshake, capture addr1, addr2, des_addr and converted fraction, go to RD1.
REQ-021 in_valid while not IDLE is ignored; the generator holds the request until in_ready.
REQ-022 RD1: mem_rd_en=1, mem_rd_addr=addr1.
REQ-023 RD2: mem_rd_en=1, mem_rd_addr=addr2; register p1 = mem_rd_data.
REQ-024 CALC: register p2 = mem_rd_data; compute and register the result.
REQ-025 WR: mem_wr_en=1, mem_wr_addr=des_addr, mem_wr_data=result; pix_count increments by 1.
REQ-026 Throughput is one pixel per 5 cycles. The write strobe is asserted in the 4th cycle after the handshake edge.
REQ-027 Fraction conversion to Q0.8 unsigned f8, with e = exponent[14:10] and N = {1, mantissa[9:0]}: e==0 -> 0; e>=15 (value >= 1.0, incl. inf/NaN) -> 255; else f8 = N >> (17-e), truncating, with a shift >= 11 giving 0. The sign bit is ignored.
REQ-028 Arithmetic: d = p2 - p1 as signed PIX_W+1; prod = d * f8 as signed 2*PIX_W+1; result = p1 + (prod >>> 8) (arithmetic shift, floor); clip to [0, 2^PIX_W-1].
REQ-029 addr1 == addr2 is legal and reads the same address twice; the result is p1.
REQ-030 Outside RD1/RD2, mem_rd_en=0 and mem_rd_addr holds its last value. Outside WR, mem_wr_en=0.

Reset
REQ-031 Reset asynchronously forces: state IDLE; in_ready=1 after release; busy, mem_rd_en and mem_wr_en = 0; all addresses, mem_wr_data, pix_count and internal registers = 0.
REQ-032 Reset asserted mid-operation aborts the pixel. No write is issued for it, and it is not counted.

Structure
REQ-033 The shared header (parameters.h) holds ADDR_SZ, PIX_W default and the FSM state encodings.
REQ-034 The half-to-Q0.8 conversion is a combinational sub-module half_to_q8 (in 16, out 8), instantiated once on the in_fraction input path.
REQ-035 The FSM, the datapath registers and pix_count reside in resize_interp_engine; no other sub-modules.

Verification
REQ-036 mem[10]=100, mem[11]=200, fraction 0x3800, des 500 -> one write to addr 500 with data 150, 4th cycle after the handshake.
REQ-037 p1=200, p2=100, fraction 0x3400 (f8=64) -> write data 175; p1=0, p2=255, fraction 0x3C00 (f8=255) -> write data 254.
REQ-038 fraction 0x0000 and 0x1000 (f8=0) -> write data equals p1; addr1 == addr2 -> data p1, with two reads of the same address.
REQ-039 in_valid held high with two queued requests -> handshakes 5 cycles apart, in_ready low for 4 cycles after each; pix_count=2 afterwards; exactly two mem_wr_en pulses.
REQ-040 reset_n pulled low during CALC -> mem_wr_en never asserted for that pixel, pix_count unchanged at 0, outputs at reset values; after release, in_ready=1 and the next request completes normally.
